// File: rtl/tictactoe_pkg.sv
// -----------------------------------------------------------------------------
// tictactoe_pkg
// Shared definitions for the tic-tac-toe square selector and the game FSM:
// board dimensions, FSM state encoding, button indices and small index helpers
// (one-hot decode, modulo-9 reduction, cursor movement with wrap-around).
// -----------------------------------------------------------------------------
package tictactoe_pkg;

    localparam int NUM_CUADROS = 9;
    localparam int GRID        = 3;

    // Index of each debounced push-button inside the button vector
    localparam int B_SEL       = 0;
    localparam int B_UP        = 1;
    localparam int B_DOWN      = 2;
    localparam int B_LEFT      = 3;
    localparam int B_RIGHT     = 4;
    localparam int NUM_BOTONES = 5;

    typedef logic [3:0] idx_t;

    localparam idx_t IDX_CENTRO = 4'd4;

    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        BUSCA  = 2'd1,
        EMITE  = 2'd2,
        SUELTA = 2'd3
    } estado_t;

    typedef enum logic [2:0] {
        MOV_NINGUNO = 3'd0,
        MOV_ARRIBA  = 3'd1,
        MOV_ABAJO   = 3'd2,
        MOV_IZQ     = 3'd3,
        MOV_DER     = 3'd4
    } mov_t;

    // One-hot decode of a square index; indices above 8 decode to zero
    function automatic logic [8:0] onehot9(input idx_t idx);
        onehot9 = 9'd1 << idx;
    endfunction

    // Reduce a 9-bit value to a square index 0..8
    function automatic idx_t mod9(input logic [8:0] v);
        logic [8:0] r;
        r    = v % 9'd9;
        mod9 = r[3:0];
    endfunction

    // Next square index in scan order, wrapping 8 -> 0
    function automatic idx_t inc_mod9(input idx_t idx);
        if (idx >= 4'd8) begin
            inc_mod9 = 4'd0;
        end else begin
            inc_mod9 = idx + 4'd1;
        end
    endfunction

    // Move the cursor one step; rows and columns wrap inside the 3x3 grid
    function automatic idx_t mover(input idx_t idx, input mov_t mov);
        idx_t fila;
        idx_t col;
        fila = (idx >= 4'd6) ? 4'd2 : ((idx >= 4'd3) ? 4'd1 : 4'd0);
        col  = idx - fila * 4'd3;
        case (mov)
            MOV_ARRIBA: fila = (fila == 4'd0) ? 4'd2 : fila - 4'd1;
            MOV_ABAJO:  fila = (fila == 4'd2) ? 4'd0 : fila + 4'd1;
            MOV_IZQ:    col  = (col  == 4'd0) ? 4'd2 : col  - 4'd1;
            MOV_DER:    col  = (col  == 4'd2) ? 4'd0 : col  + 4'd1;
            default:    fila = fila;
        endcase
        mover = fila * 4'd3 + col;
    endfunction

endpackage

// File: rtl/antirrebote.sv
// -----------------------------------------------------------------------------
// antirrebote
// Two-flop synchronizer followed by a debouncer for one raw push-button.
// The debounced level only follows the synchronized input after
// DEBOUNCE_CYCLES consecutive samples that disagree with the current level.
//
// Ports:
//   clk      in   sampling clock (rising edge)
//   reset_n  in   asynchronous active-low reset (level, counter, sync -> 0)
//   boton    in   raw asynchronous button, active-high
//   nivel    out  debounced button level
// -----------------------------------------------------------------------------
module antirrebote #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic boton,
    output logic nivel
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             nivel_r;
    logic [CNT_W-1:0] cnt_r;

    // Two-flop synchronizer for the asynchronous button input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= boton;
            sync2_r <= sync1_r;
        end
    end

    // Debouncer: any sample equal to the current level restarts the count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nivel_r <= 1'b0;
            cnt_r   <= '0;
        end else if (sync2_r == nivel_r) begin
            cnt_r   <= '0;
        end else if (cnt_r == CNT_MAX) begin
            nivel_r <= sync2_r;
            cnt_r   <= '0;
        end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
        end
    end

    assign nivel = nivel_r;

endmodule

// File: rtl/selector_cuadro.sv
// -----------------------------------------------------------------------------
// selector_cuadro
// Cursor-based square selector for a 3x3 tic-tac-toe board. Five debounced
// buttons move a cursor (with wrap-around) and select the square under it.
// An accepted selection produces a one-cycle one-hot strobe on cuadro; a
// refused selection produces a one-cycle pulse on rechazo.
//
// Optional feature (macro RANDOM_MOVE_EN): adds the randomClick input, its
// debouncer and a 9-bit free-running LFSR (x^9 + x^5 + 1). A random request
// searches, starting from LFSR mod 9, for the first free square.
//
// Ports:
//   clk_100MHz   in   sole clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   btn_up/down/left/right/sel  in  raw push-buttons, active-high
//   ocupado      in   [8:0] occupied squares (bit i = square i taken)
//   enable       in   game FSM accepts a move this cycle
//   randomClick  in   raw random-move request (RANDOM_MOVE_EN only)
//   cuadro       out  [8:0] one-hot selected-square strobe, one cycle per move
//   cursor       out  [8:0] one-hot current cursor square
//   rechazo      out  one-cycle pulse when a request is refused
// -----------------------------------------------------------------------------
module selector_cuadro
    import tictactoe_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 1000000,
    parameter logic [8:0] LFSR_SEED       = 9'h1A5
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    input  logic [8:0] ocupado,
    input  logic       enable,
`ifdef RANDOM_MOVE_EN
    input  logic       randomClick,
`endif
    output logic [8:0] cuadro,
    output logic [8:0] cursor,
    output logic       rechazo
);

    logic [NUM_BOTONES-1:0] boton_s;
    logic [NUM_BOTONES-1:0] nivel_s;
    logic [NUM_BOTONES-1:0] nivel_prev_r;
    logic [NUM_BOTONES-1:0] evento_s;
    logic                   rnd_nivel_s;
    logic                   rnd_evento_s;

    estado_t    estado_r;
    estado_t    estado_sig_s;
    idx_t       idx_r;
    idx_t       idx_sig_s;
    logic       rechazo_sig_s;
    logic [8:0] cuadro_sig_s;
    logic [8:0] cursor_sig_s;
    logic [8:0] cuadro_r;
    logic [8:0] cursor_r;
    logic       rechazo_r;

    assign boton_s[B_SEL]   = btn_sel;
    assign boton_s[B_UP]    = btn_up;
    assign boton_s[B_DOWN]  = btn_down;
    assign boton_s[B_LEFT]  = btn_left;
    assign boton_s[B_RIGHT] = btn_right;

    for (genvar g = 0; g < NUM_BOTONES; g++) begin : g_boton
        antirrebote #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_antirrebote (
            .clk    (clk_100MHz),
            .reset_n(reset_n),
            .boton  (boton_s[g]),
            .nivel  (nivel_s[g])
        );
    end

    // Previous debounced levels for rising-edge detection
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            nivel_prev_r <= '0;
        end else begin
            nivel_prev_r <= nivel_s;
        end
    end

    // Single-cycle event on each debounced rising edge; falling edges ignored
    assign evento_s = nivel_s & ~nivel_prev_r;

`ifdef RANDOM_MOVE_EN
    logic       rnd_prev_r;
    logic [8:0] lfsr_r;
    idx_t       cand_r;
    idx_t       cand_sig_s;
    logic [3:0] busq_r;
    logic [3:0] busq_sig_s;

    antirrebote #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_antirrebote_rnd (
        .clk    (clk_100MHz),
        .reset_n(reset_n),
        .boton  (randomClick),
        .nivel  (rnd_nivel_s)
    );

    // Random-request edge register and free-running LFSR x^9 + x^5 + 1
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            rnd_prev_r <= 1'b0;
            lfsr_r     <= LFSR_SEED;
        end else begin
            rnd_prev_r <= rnd_nivel_s;
            lfsr_r     <= {lfsr_r[7:0], lfsr_r[8] ^ lfsr_r[4]};
        end
    end

    assign rnd_evento_s = rnd_nivel_s & ~rnd_prev_r;
`else
    assign rnd_nivel_s  = 1'b0;
    assign rnd_evento_s = 1'b0;
`endif

    // FSM state register plus cursor index and search bookkeeping
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            estado_r <= ESPERA;
            idx_r    <= IDX_CENTRO;
`ifdef RANDOM_MOVE_EN
            cand_r   <= 4'd0;
            busq_r   <= 4'd0;
`endif
        end else begin
            estado_r <= estado_sig_s;
            idx_r    <= idx_sig_s;
`ifdef RANDOM_MOVE_EN
            cand_r   <= cand_sig_s;
            busq_r   <= busq_sig_s;
`endif
        end
    end

    // Next-state logic; event priority sel > random > up > down > left > right
    always_comb begin
        estado_sig_s  = estado_r;
        idx_sig_s     = idx_r;
        rechazo_sig_s = 1'b0;
`ifdef RANDOM_MOVE_EN
        cand_sig_s    = cand_r;
        busq_sig_s    = busq_r;
`endif
        case (estado_r)
            ESPERA: begin
                if (evento_s[B_SEL]) begin
                    if (enable && ((ocupado & onehot9(idx_r)) == 9'd0)) begin
                        estado_sig_s = EMITE;
                    end else begin
                        rechazo_sig_s = 1'b1;
                    end
                end else if (rnd_evento_s) begin
`ifdef RANDOM_MOVE_EN
                    if (enable) begin
                        estado_sig_s = BUSCA;
                        cand_sig_s   = mod9(lfsr_r);
                        busq_sig_s   = 4'd0;
                    end else begin
                        rechazo_sig_s = 1'b1;
                    end
`else
                    rechazo_sig_s = 1'b1;
`endif
                end else if (evento_s[B_UP]) begin
                    idx_sig_s = mover(idx_r, MOV_ARRIBA);
                end else if (evento_s[B_DOWN]) begin
                    idx_sig_s = mover(idx_r, MOV_ABAJO);
                end else if (evento_s[B_LEFT]) begin
                    idx_sig_s = mover(idx_r, MOV_IZQ);
                end else if (evento_s[B_RIGHT]) begin
                    idx_sig_s = mover(idx_r, MOV_DER);
                end else begin
                    estado_sig_s = ESPERA;
                end
            end
            BUSCA: begin
`ifdef RANDOM_MOVE_EN
                // One candidate per cycle; nine misses means the board is full
                if ((ocupado & onehot9(cand_r)) == 9'd0) begin
                    idx_sig_s    = cand_r;
                    estado_sig_s = EMITE;
                end else if (busq_r == 4'd8) begin
                    rechazo_sig_s = 1'b1;
                    estado_sig_s  = ESPERA;
                end else begin
                    cand_sig_s = inc_mod9(cand_r);
                    busq_sig_s = busq_r + 4'd1;
                end
`else
                estado_sig_s = ESPERA;
`endif
            end
            EMITE: begin
                // The request was committed last cycle, so enable is not rechecked
                estado_sig_s = SUELTA;
            end
            SUELTA: begin
                if (!nivel_s[B_SEL] && !rnd_nivel_s) begin
                    estado_sig_s = ESPERA;
                end else begin
                    estado_sig_s = SUELTA;
                end
            end
            default: begin
                estado_sig_s = ESPERA;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with it
    always_comb begin
        cursor_sig_s = onehot9(idx_sig_s);
        if (estado_sig_s == EMITE) begin
            cuadro_sig_s = onehot9(idx_sig_s);
        end else begin
            cuadro_sig_s = 9'd0;
        end
    end

    // Output registers; reset clears the strobe immediately
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            cuadro_r  <= 9'd0;
            cursor_r  <= onehot9(IDX_CENTRO);
            rechazo_r <= 1'b0;
        end else begin
            cuadro_r  <= cuadro_sig_s;
            cursor_r  <= cursor_sig_s;
            rechazo_r <= rechazo_sig_s;
        end
    end

    assign cuadro  = cuadro_r;
    assign cursor  = cursor_r;
    assign rechazo = rechazo_r;

endmodule

// File: tb/tb_selector_cuadro.sv
// -----------------------------------------------------------------------------
// tb_selector_cuadro
// Self-checking bench for selector_cuadro with DEBOUNCE_CYCLES = 4.
// A clean press driven just after a falling edge becomes a debounced edge
// after 2 synchronizer flops plus 4 stable samples (6 rising edges); the
// resulting cursor change, cuadro strobe or rechazo pulse is visible one
// edge later, i.e. at the 7th falling edge after the press.
// The cursor is modelled as (row, col) with modulo-3 arithmetic.
// -----------------------------------------------------------------------------
module tb_selector_cuadro;

    localparam int LAT  = 7;
    localparam int HOLD = 12;
    localparam int TAIL = 12;

    logic       clk;
    logic       reset_n;
    logic       btn_up, btn_down, btn_left, btn_right, btn_sel;
    logic [8:0] ocupado;
    logic       enable;
`ifdef RANDOM_MOVE_EN
    logic       randomClick;
`endif
    logic [8:0] cuadro;
    logic [8:0] cursor;
    logic       rechazo;

    int total = 0;
    int bad   = 0;
    int exp_idx = 4;

    logic [8:0] obs_cuadro [0:63];
    logic [8:0] obs_cursor [0:63];
    logic       obs_rech   [0:63];

    selector_cuadro #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_100MHz(clk),
        .reset_n   (reset_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_sel   (btn_sel),
        .ocupado   (ocupado),
        .enable    (enable),
`ifdef RANDOM_MOVE_EN
        .randomClick(randomClick),
`endif
        .cuadro    (cuadro),
        .cursor    (cursor),
        .rechazo   (rechazo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] oh(input int i);
        logic [8:0] one;
        one = 9'd1;
        return one << i;
    endfunction

    // Reference cursor movement: 0 up, 1 down, 2 left, 3 right
    function automatic int move_model(input int i, input int dir);
        int r, c;
        r = i / 3;
        c = i % 3;
        case (dir)
            0: r = (r + 2) % 3;
            1: r = (r + 1) % 3;
            2: c = (c + 2) % 3;
            default: c = (c + 1) % 3;
        endcase
        return r * 3 + c;
    endfunction

    // bits = {sel, up, down, left, right}
    task automatic set_btns(input logic [4:0] bits);
        btn_sel   = bits[4];
        btn_up    = bits[3];
        btn_down  = bits[2];
        btn_left  = bits[1];
        btn_right = bits[0];
    endtask

    // Press the given buttons for HOLD cycles, release, record TAIL more cycles
    task automatic run_press(input logic [4:0] bits);
        @(negedge clk);
        set_btns(bits);
        for (int k = 1; k <= HOLD + TAIL; k++) begin
            @(negedge clk);
            obs_cuadro[k] = cuadro;
            obs_cursor[k] = cursor;
            obs_rech[k]   = rechazo;
            if (k == HOLD) set_btns(5'b00000);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_btns(5'b00000);
        ocupado = 9'd0;
        enable  = 1'b1;
`ifdef RANDOM_MOVE_EN
        randomClick = 1'b0;
`endif
        repeat (3) @(negedge clk);
        total++; if (cursor !== 9'b000010000) begin bad++; $display("FAIL reset_cursor got=%b want=%b", cursor, 9'b000010000); end
        total++; if (cuadro !== 9'd0) begin bad++; $display("FAIL reset_cuadro got=%b want=0", cuadro); end
        total++; if (rechazo !== 1'b0) begin bad++; $display("FAIL reset_rechazo got=%b want=0", rechazo); end
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        total++; if (cursor !== 9'b000010000) begin bad++; $display("FAIL post_reset_cursor got=%b want=%b", cursor, 9'b000010000); end
        total++; if (cuadro !== 9'd0) begin bad++; $display("FAIL post_reset_cuadro got=%b want=0", cuadro); end
        exp_idx = 4;
    endtask

    task automatic test_cursor_wrap();
        int want [0:2];
        want[0] = 5; want[1] = 3; want[2] = 4;
        for (int p = 0; p < 3; p++) begin
            run_press(5'b00001);
            for (int k = 1; k <= HOLD + TAIL; k++) begin
                total++;
                if (obs_cursor[k] !== ((k < LAT) ? oh(exp_idx) : oh(want[p]))) begin
                    bad++; $display("FAIL wrap_cursor press=%0d k=%0d got=%b want=%b", p, k, obs_cursor[k], (k < LAT) ? oh(exp_idx) : oh(want[p]));
                end
                total++;
                if (obs_cuadro[k] !== 9'd0) begin bad++; $display("FAIL wrap_cuadro press=%0d k=%0d got=%b want=0", p, k, obs_cuadro[k]); end
            end
            exp_idx = want[p];
        end
    endtask

    task automatic test_select();
        ocupado = 9'd0;
        enable  = 1'b1;
        run_press(5'b10000);
        for (int k = 1; k <= HOLD + TAIL; k++) begin
            total++;
            if (obs_cuadro[k] !== ((k == LAT) ? 9'b000010000 : 9'd0)) begin
                bad++; $display("FAIL select_cuadro k=%0d got=%b want=%b", k, obs_cuadro[k], (k == LAT) ? 9'b000010000 : 9'd0);
            end
            total++;
            if (obs_rech[k] !== 1'b0) begin bad++; $display("FAIL select_rechazo k=%0d got=%b want=0", k, obs_rech[k]); end
        end
    endtask

    task automatic test_reject();
        for (int pass = 0; pass < 2; pass++) begin
            ocupado = (pass == 0) ? 9'b000010000 : 9'd0;
            enable  = (pass == 0) ? 1'b1 : 1'b0;
            run_press(5'b10000);
            for (int k = 1; k <= HOLD + TAIL; k++) begin
                total++;
                if (obs_rech[k] !== (k == LAT)) begin bad++; $display("FAIL reject_rechazo pass=%0d k=%0d got=%b want=%b", pass, k, obs_rech[k], (k == LAT)); end
                total++;
                if (obs_cuadro[k] !== 9'd0) begin bad++; $display("FAIL reject_cuadro pass=%0d k=%0d got=%b want=0", pass, k, obs_cuadro[k]); end
            end
        end
        ocupado = 9'd0;
        enable  = 1'b1;
    endtask

    task automatic test_simultaneous();
        ocupado = 9'd0;
        enable  = 1'b1;
        run_press(5'b11000);
        for (int k = 1; k <= HOLD + TAIL; k++) begin
            total++;
            if (obs_cuadro[k] !== ((k == LAT) ? oh(exp_idx) : 9'd0)) begin
                bad++; $display("FAIL simul_cuadro k=%0d got=%b want=%b", k, obs_cuadro[k], (k == LAT) ? oh(exp_idx) : 9'd0);
            end
            total++;
            if (obs_cursor[k] !== oh(exp_idx)) begin bad++; $display("FAIL simul_cursor k=%0d got=%b want=%b", k, obs_cursor[k], oh(exp_idx)); end
        end
    endtask

    task automatic test_random_moves();
        for (int it = 0; it < 24; it++) begin
            int op;
            int new_idx;
            logic [8:0] want_c;
            logic want_r;
            logic [4:0] bits;
            op      = $urandom_range(0, 4);
            ocupado = 9'($urandom_range(0, 511));
            enable  = ($urandom_range(0, 3) != 0);
            new_idx = exp_idx;
            want_c  = 9'd0;
            want_r  = 1'b0;
            if (op == 0) begin
                bits = 5'b10000;
                if (enable && !ocupado[exp_idx]) want_c = oh(exp_idx);
                else want_r = 1'b1;
            end else begin
                bits = 5'b01000 >> (op - 1);
                new_idx = move_model(exp_idx, op - 1);
            end
            run_press(bits);
            for (int k = 1; k <= HOLD + TAIL; k++) begin
                total++;
                if (obs_cuadro[k] !== ((k == LAT) ? want_c : 9'd0)) begin
                    bad++; $display("FAIL rand_cuadro it=%0d op=%0d k=%0d got=%b want=%b", it, op, k, obs_cuadro[k], (k == LAT) ? want_c : 9'd0);
                end
                total++;
                if (obs_rech[k] !== ((k == LAT) ? want_r : 1'b0)) begin
                    bad++; $display("FAIL rand_rechazo it=%0d op=%0d k=%0d got=%b want=%b", it, op, k, obs_rech[k], (k == LAT) ? want_r : 1'b0);
                end
                total++;
                if (obs_cursor[k] !== ((k < LAT) ? oh(exp_idx) : oh(new_idx))) begin
                    bad++; $display("FAIL rand_cursor it=%0d op=%0d k=%0d got=%b want=%b", it, op, k, obs_cursor[k], (k < LAT) ? oh(exp_idx) : oh(new_idx));
                end
            end
            exp_idx = new_idx;
        end
        ocupado = 9'd0;
        enable  = 1'b1;
    endtask

    task automatic test_bounce();
        @(negedge clk);
        for (int p = 0; p < 6; p++) begin
            set_btns(5'b10001);
            repeat (2) @(negedge clk);
            set_btns(5'b00000);
            repeat (2) @(negedge clk);
            total++;
            if (cuadro !== 9'd0) begin bad++; $display("FAIL bounce_cuadro p=%0d got=%b want=0", p, cuadro); end
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            total++;
            if (cursor !== oh(exp_idx) || cuadro !== 9'd0) begin
                bad++; $display("FAIL bounce_settle k=%0d cursor=%b want=%b cuadro=%b want=0", k, cursor, oh(exp_idx), cuadro);
            end
        end
    endtask

    task automatic test_reset_during_emite();
        ocupado = 9'd0;
        enable  = 1'b1;
        @(negedge clk);
        set_btns(5'b10000);
        repeat (LAT) @(negedge clk);
        total++;
        if (cuadro !== oh(exp_idx)) begin bad++; $display("FAIL emite_before_reset got=%b want=%b", cuadro, oh(exp_idx)); end
        #1 reset_n = 1'b0;
        #1;
        total++;
        if (cuadro !== 9'd0) begin bad++; $display("FAIL emite_reset_cuadro got=%b want=0", cuadro); end
        set_btns(5'b00000);
        exp_idx = 4;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            total++;
            if (cuadro !== 9'd0 || cursor !== oh(exp_idx)) begin
                bad++; $display("FAIL emite_after_reset k=%0d cuadro=%b want=0 cursor=%b want=%b", k, cuadro, cursor, oh(exp_idx));
            end
        end
    endtask

    task automatic test_hold_across_reset();
        @(negedge clk);
        reset_n = 1'b0;
        set_btns(5'b00001);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        exp_idx = 4;
        for (int k = 1; k <= HOLD + TAIL; k++) begin
            @(negedge clk);
            total++;
            if (cursor !== ((k < LAT) ? oh(4) : oh(5))) begin
                bad++; $display("FAIL hold_reset_cursor k=%0d got=%b want=%b", k, cursor, (k < LAT) ? oh(4) : oh(5));
            end
            if (k == HOLD) set_btns(5'b00000);
        end
        exp_idx = 5;
    endtask

`ifdef RANDOM_MOVE_EN
    task automatic test_random();
        int seen_c, seen_r;
        logic [8:0] got_c;
        for (int pass = 0; pass < 2; pass++) begin
            ocupado = (pass == 0) ? 9'h1FE : 9'h1FF;
            enable  = 1'b1;
            seen_c  = 0;
            seen_r  = 0;
            got_c   = 9'd0;
            @(negedge clk);
            randomClick = 1'b1;
            for (int k = 1; k <= 30; k++) begin
                @(negedge clk);
                if (cuadro !== 9'd0) begin seen_c++; got_c = cuadro; end
                if (rechazo === 1'b1) seen_r++;
                if (k == 20) randomClick = 1'b0;
            end
            total++;
            if (seen_c !== ((pass == 0) ? 1 : 0)) begin bad++; $display("FAIL random_pulses pass=%0d got=%0d want=%0d", pass, seen_c, (pass == 0) ? 1 : 0); end
            total++;
            if (seen_r !== ((pass == 0) ? 0 : 1)) begin bad++; $display("FAIL random_rechazo pass=%0d got=%0d want=%0d", pass, seen_r, (pass == 0) ? 0 : 1); end
            if (pass == 0) begin
                total++;
                if (got_c !== 9'b000000001) begin bad++; $display("FAIL random_cuadro got=%b want=%b", got_c, 9'b000000001); end
                total++;
                if (cursor !== oh(0)) begin bad++; $display("FAIL random_cursor got=%b want=%b", cursor, oh(0)); end
                exp_idx = 0;
            end
        end
        ocupado = 9'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_cursor_wrap();
        test_select();
        test_reject();
        test_simultaneous();
        test_random_moves();
        test_bounce();
        test_reset_during_emite();
        test_hold_across_reset();
`ifdef RANDOM_MOVE_EN
        test_random();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/selector_cuadro.md
SELECTOR_CUADRO -- requirements
Module: selector_cuadro

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-cycles before a button level is accepted (10 ms at 100 MHz).
REQ-002 SHALL have parameter LFSR_SEED, default 9'h1A5, nonzero reset value of random LFSR.
REQ-003 clk_100MHz  in  1  sole clock, rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 btn_up, btn_down, btn_left, btn_right, btn_sel  in  1 each  raw asynchronous push-buttons, active-high.
REQ-006 ocupado  in  9  occupancy map (x OR o from board registers), bit i = square i taken.
REQ-007 enable  in  1  game FSM accepts a move this cycle.
REQ-008 randomClick  in  1  raw random-move request (present only with RANDOM_MOVE_EN).
REQ-009 cuadro  out  9  one-hot selected-square strobe, high exactly one cycle per accepted move.
REQ-010 cursor  out  9  one-hot current cursor square (display highlight).
REQ-011 rechazo  out  1  one-cycle pulse when a move request is refused.

Function
REQ-012 Each button SHALL pass a 2-FF synchronizer then a debouncer; debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-013 A debounced rising edge SHALL produce a single-cycle event in cycle N; falling edges produce none.
REQ-014 Cursor index idx 0..8, row=idx/3, col=idx%3; reset value idx=4 (center), cursor=9'b000010000.
REQ-015 Right/left SHALL change col by +1/-1 with wrap 2->0 / 0->2 inside the same row; down/up change row with wrap 2->0 / 0->2 in the same column; cursor updates in cycle N+1.
REQ-016 Simultaneous events in one cycle SHALL be resolved by priority sel > random > up > down > left > right; lower-priority events that cycle are discarded.
REQ-017 FSM states ESPERA, BUSCA, EMITE, SUELTA; reset state ESPERA.
REQ-018 ESPERA + sel event: if enable=1 and ocupado[idx]=0 -> EMITE; else rechazo=1 in cycle N+1, stay ESPERA.
REQ-019 EMITE SHALL last one cycle, drive cuadro=onehot(idx), then go to SUELTA; cuadro=0 in every other state.
REQ-020 SUELTA SHALL ignore all events until debounced btn_sel and randomClick are both low, then return to ESPERA; cursor moves are also blocked.
REQ-021 Latency: sel debounced edge in cycle N -> cuadro pulse in cycle N+1.
REQ-022 If enable falls while in EMITE the pulse SHALL still complete (request was committed one cycle earlier).
REQ-023 If ocupado=9'h1FF, any select/random request SHALL yield rechazo and no cuadro pulse.

Reset
REQ-024 reset_n low SHALL asynchronously force: state ESPERA, idx=4, cuadro=0, rechazo=0, synchronizer/debouncer levels 0, debounce counters 0, LFSR=LFSR_SEED.
REQ-025 Reset mid-EMITE SHALL drop cuadro to 0 immediately; no pulse after deassertion.
REQ-026 Buttons held across reset deassertion SHALL produce one event after DEBOUNCE_CYCLES.

Configuration
REQ-027 Macro RANDOM_MOVE_EN defined: randomClick port, its debouncer and a 9-bit free-running LFSR (x^9+x^5+1) exist.
REQ-028 With RANDOM_MOVE_EN, random event in ESPERA with enable=1 -> BUSCA: candidate = LFSR mod 9 latched, then incremented mod 9 one per cycle until ocupado[candidate]=0 (max 9 cycles) -> idx=candidate, EMITE; none free -> rechazo, ESPERA.
REQ-029 Without RANDOM_MOVE_EN: no randomClick port, no LFSR, BUSCA state unreachable/absent; behaviour otherwise identical.

Structure
REQ-030 Package tictactoe_pkg SHALL hold NUM_CUADROS=9, GRID=3, the FSM state enum and a onehot9(idx) function, shared with the game FSM.
REQ-031 Sub-module antirrebote (synchronizer + debouncer, parameter DEBOUNCE_CYCLES) SHALL be instantiated once per button.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 Reset, press btn_right 3 times -> cursor 4->5->3->4 (wrap within row), cuadro never asserted.
REQ-033 ocupado=0, enable=1, press btn_sel -> cuadro=9'b000010000 for exactly one cycle, one cycle after debounced edge; holding btn_sel gives no second pulse.
REQ-034 ocupado=9'b000010000, press btn_sel -> rechazo one cycle, cuadro stays 0; repeat with enable=0 -> rechazo.
REQ-035 btn_up and btn_sel debounced in same cycle -> cuadro=onehot(4), cursor unchanged.
REQ-036 Button bounce shorter than 4 cycles -> no event; reset_n asserted during EMITE -> cuadro=0 same cycle.
REQ-037 RANDOM_MOVE_EN, ocupado=9'h1FE -> random request yields cuadro=9'b000000001, cursor=onehot(0); ocupado=9'h1FF -> rechazo only.
